// File: rtl/fir_frame_arbiter_if.sv
// Two-channel framed sample source bundle for fir_frame_arbiter.
// Each channel is a valid/ready stream with a last-of-frame marker.
interface fir_frame_arbiter_if #(
  parameter int DATA_WIDTH = 19
);
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s0_valid;
  logic                  s0_last;
  logic                  s0_ready;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;
  logic                  s1_last;
  logic                  s1_ready;

  modport master (
    output s0_data, s0_valid, s0_last,
    input  s0_ready,
    output s1_data, s1_valid, s1_last,
    input  s1_ready
  );

  modport slave (
    input  s0_data, s0_valid, s0_last,
    output s0_ready,
    input  s1_data, s1_valid, s1_last,
    output s1_ready
  );
endinterface

// File: rtl/fir_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one FIR between two sources.
// Flushes TAPS-1 zeros after each frame and tags outputs by channel.
module fir_frame_arbiter #(
  parameter int DATA_WIDTH = 19,
  parameter int OUT_WIDTH  = 36,
  parameter int TAPS       = 17,
  parameter int PIPE_LAT   = 2,
  parameter int MAX_FRAME  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fir_frame_arbiter_if.slave   src,
  output logic [DATA_WIDTH-1:0] flt_in,
  output logic                 flt_valid,
  input  logic [OUT_WIDTH-1:0] flt_out,
  input  logic                 flt_valid_out,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_chan,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err
);

  localparam int CW  = $clog2(MAX_FRAME) + 1;
  localparam int TW  = $clog2(MAX_FRAME + TAPS) + 1;
  localparam int FW  = $clog2(TAPS) + 1;
  localparam int TOW = $clog2(PIPE_LAT + TAPS) + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]     state;
  logic           gchan;
  logic           ptr;
  logic [CW-1:0]  beat_cnt;
  logic [TW-1:0]  out_cnt;
  logic [FW-1:0]  flush_cnt;
  logic [TOW-1:0] drain_cnt;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  gnt;
  logic [TW-1:0]         target;
  logic                  fwd;
  logic                  done;
  logic                  drain_to;
  logic                  beat_max;

  assign sel_valid = gchan ? src.s1_valid : src.s0_valid;
  assign sel_last  = gchan ? src.s1_last  : src.s0_last;
  assign sel_data  = gchan ? src.s1_data  : src.s0_data;

  assign src.s0_ready = (state == STREAM) && !gchan;
  assign src.s1_ready = (state == STREAM) &&  gchan;

  assign accept = (state == STREAM) && sel_valid;
  assign busy   = (state != IDLE);

  // Pointer channel wins a tie; a lone requester always wins.
  assign gnt = (src.s0_valid && src.s1_valid) ? ptr : src.s1_valid;

  // Every frame yields its own beats plus one output per flush zero.
  assign target   = TW'(beat_cnt) + TW'(TAPS - 1);
  assign fwd      = flt_valid_out && busy && (out_cnt < target);
  assign done     = (out_cnt == target);
  assign drain_to = (drain_cnt == TOW'(PIPE_LAT + TAPS - 1));
  assign beat_max = (beat_cnt == CW'(MAX_FRAME - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gchan     <= 1'b0;
      ptr       <= 1'b0;
      beat_cnt  <= '0;
      out_cnt   <= '0;
      flush_cnt <= '0;
      drain_cnt <= '0;
      flt_in    <= '0;
      flt_valid <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_chan    <= 1'b0;
      m_last    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err       <= 1'b0;
      flt_valid <= 1'b0;
      flt_in    <= '0;
      m_valid   <= fwd;
      m_last    <= fwd && ((out_cnt + TW'(1)) == target);
      if (fwd) begin
        m_data  <= flt_out;
        m_chan  <= gchan;
        out_cnt <= out_cnt + TW'(1);
      end
      case (state)
        IDLE: begin
          if (src.s0_valid || src.s1_valid) begin
            gchan    <= gnt;
            beat_cnt <= '0;
            out_cnt  <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            flt_valid <= 1'b1;
            flt_in    <= sel_data;
            beat_cnt  <= beat_cnt + CW'(1);
            flush_cnt <= '0;
            if (sel_last) begin
              state <= FLUSH;
            end else if (beat_max) begin
              state <= FLUSH;
              err   <= 1'b1;
            end
          end
        end
        FLUSH: begin
          flt_valid <= 1'b1;
          if (flush_cnt == FW'(TAPS - 2)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (done) begin
            state <= IDLE;
            ptr   <= ~gchan;
          end else if (drain_to) begin
            state <= IDLE;
            ptr   <= ~gchan;
            err   <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + TOW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
